hilo_muldiv: RTL and testbench

//  Multi-cycle multiply/divide unit that owns the HI/LO register pair.

---
 rtl/hilo_muldiv.sv | 194 +++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// ============================================================================
// Module   : hilo_muldiv
// Brief    : Iterative MIPS-style multiply/divide unit owning the HI/LO pair.
//            Optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hiOut,
    output logic [W-1:0] loOut
);

    localparam int           CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  wh_q, wh_d;     // working upper half (partial product / remainder)
    logic [W-1:0]  wl_q, wl_d;     // working lower half (multiplier / dividend->quotient)
    logic [W-1:0]  dvs_q, dvs_d;   // magnitude of b
    logic          mul_q, mul_d;
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;
    logic          div0_q, div0_d;
    logic          done_q, done_d;

    logic            w_accept;
    logic            w_iter_op;
    logic            w_signed;
    logic [W-1:0]    w_mag_a;
    logic [W-1:0]    w_mag_b;
    logic [W:0]      w_madd;
    logic [W-1:0]    w_mul_hi, w_mul_lo;
    logic [W:0]      w_shift;
    logic            w_qbit;
    logic [W-1:0]    w_div_hi, w_div_lo;
    logic [W-1:0]    w_step_hi, w_step_lo;
    logic [2*W-1:0]  w_mul_raw;
    logic [2*W-1:0]  w_mul_fix;
    logic [W-1:0]    w_fin_hi, w_fin_lo;
    logic            w_last;

    assign w_accept  = (state_q == S_IDLE) && start;
    assign w_iter_op = ~op[2];
    assign w_signed  = ~op[0];
    assign w_mag_a   = (w_signed && a[W-1]) ? -a : a;
    assign w_mag_b   = (w_signed && b[W-1]) ? -b : b;

    // Shift-add multiply step: conditionally add multiplicand, shift pair right.
    assign w_madd   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, dvs_q} : {(W+1){1'b0}});
    assign w_mul_hi = w_madd[W:1];
    assign w_mul_lo = {w_madd[0], wl_q[W-1:1]};

    // Restoring divide step: shift remainder left, try subtracting the divisor.
    assign w_shift  = {wh_q, wl_q[W-1]};
    assign w_qbit   = (w_shift >= {1'b0, dvs_q});
    assign w_div_hi = w_qbit ? W'(w_shift - {1'b0, dvs_q}) : w_shift[W-1:0];
    assign w_div_lo = {wl_q[W-2:0], w_qbit};

    assign w_step_hi = mul_q ? w_mul_hi : w_div_hi;
    assign w_step_lo = mul_q ? w_mul_lo : w_div_lo;

`ifdef MULDIV_FAST_MUL_EN
    assign w_mul_raw = {{W{1'b0}}, wl_q} * {{W{1'b0}}, dvs_q};
    assign w_last    = mul_q || (cnt_q == CNT_LAST);
`else
    assign w_mul_raw = {w_step_hi, w_step_lo};
    assign w_last    = (cnt_q == CNT_LAST);
`endif

    // Sign fix-up; a zero divisor forces LO to all-ones and HI back to a.
    assign w_mul_fix = negq_q ? -w_mul_raw : w_mul_raw;

    always_comb begin
        w_fin_hi = w_mul_fix[2*W-1:W];
        w_fin_lo = w_mul_fix[W-1:0];
        if (!mul_q) begin
            w_fin_hi = negr_q ? -w_step_hi : w_step_hi;
            if (div0_q) begin
                w_fin_lo = {W{1'b1}};
            end else begin
                w_fin_lo = negq_q ? -w_step_lo : w_step_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            wh_q    <= '0;
            wl_q    <= '0;
            dvs_q   <= '0;
            mul_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wh_q    <= wh_d;
            wl_q    <= wl_d;
            dvs_q   <= dvs_d;
            mul_q   <= mul_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept && w_iter_op) state_d = S_RUN;
            S_RUN:   if (w_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        wh_d   = wh_q;
        wl_d   = wl_q;
        dvs_d  = dvs_q;
        mul_d  = mul_q;
        negq_d = negq_q;
        negr_d = negr_q;
        div0_d = div0_q;
        done_d = 1'b0;
        if (w_accept) begin
            if (w_iter_op) begin
                cnt_d  = '0;
                wh_d   = '0;
                wl_d   = w_mag_a;
                dvs_d  = w_mag_b;
                mul_d  = ~op[1];
                negq_d = w_signed && (a[W-1] ^ b[W-1]);
                negr_d = w_signed && a[W-1];
                div0_d = (b == '0);
            end else if (op == OP_MTHI) begin
                hi_d = a;
            end else if (op == OP_MTLO) begin
                lo_d = a;
            end
        end else if (state_q == S_RUN) begin
            if (w_last) begin
                hi_d   = w_fin_hi;
                lo_d   = w_fin_lo;
                done_d = 1'b1;
            end else begin
                wh_d  = w_step_hi;
                wl_d  = w_step_lo;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        busy  = (state_q == S_RUN);
        done  = done_q;
        hiOut = hi_q;
        loOut = lo_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
// ============================================================================
// Module   : tb_hilo_muldiv
// Brief    : Directed self-checking bench for hilo_muldiv (honours MULDIV_FAST_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hilo_muldiv;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int C_MUL_LAT = 1;
`else
    localparam int C_MUL_LAT = 32;
`endif
    localparam int C_DIV_LAT = 32;

    localparam logic [2:0] C_MULT  = 3'b000;
    localparam logic [2:0] C_MULTU = 3'b001;
    localparam logic [2:0] C_DIV   = 3'b010;
    localparam logic [2:0] C_DIVU  = 3'b011;
    localparam logic [2:0] C_MTHI  = 3'b100;
    localparam logic [2:0] C_MTLO  = 3'b101;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hilo_muldiv #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hiOut (hi_out),
        .loOut (lo_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one iterative op and count edges until done; optional ignored restart mid-run.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int glitch_at, input logic [W-1:0] hold_hi,
                         output int lat);
        op = o; a = x; b = y; start = 1'b1;
        tick;
        start = 1'b0;
        check("busy_after_issue", {63'd0, busy}, 64'd1);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (glitch_at != 0 && i == glitch_at) begin
                start = 1'b1; op = C_MTHI; a = 32'hDEAD_BEEF;
            end
            tick;
            start = 1'b0;
            if (glitch_at != 0 && i == glitch_at + 4) begin
                check("hi_held_during_run", {32'd0, hi_out}, {32'd0, hold_hi});
                check("busy_mid_run", {63'd0, busy}, 64'd1);
            end
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    int   lat;
    logic saw_done;

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        tick;
        tick;
        check("reset_hi", {32'd0, hi_out}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        rst = 1'b0;

        // Load HI/LO then reset
        start = 1'b1; op = C_MTHI; a = 32'h5555_5555; tick;
        op = C_MTLO; a = 32'hAAAA_AAAA; tick;
        start = 1'b0;
        check("preload", {hi_out, lo_out}, 64'h5555_5555_AAAA_AAAA);
        rst = 1'b1; tick; tick; rst = 1'b0;
        check("reset_clears_hilo", {hi_out, lo_out}, 64'd0);
        check("reset_clears_busy_done", {62'd0, busy, done}, 64'd0);

        // MULTU max*max
        do_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0, lat);
        check("multu_latency", 64'(lat), 64'(C_MUL_LAT));
        check("multu_result", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
        tick;
        check("done_single_pulse", {62'd0, busy, done}, 64'd0);

        // MULT -7*3 with ignored restart
        do_op(C_MULT, 32'hFFFF_FFF9, 32'd3, 5, 32'hFFFF_FFFE, lat);
        check("mult_latency", 64'(lat), 64'(C_MUL_LAT));
        check("mult_result", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);

        // DIV -7/2 then back-to-back DIVU by zero
        do_op(C_DIV, 32'hFFFF_FFF9, 32'd2, 0, '0, lat);
        check("div_latency", 64'(lat), 64'(C_DIV_LAT));
        check("div_result", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(C_DIVU, 32'd100, 32'd0, 0, '0, lat);
        check("divu_by0_latency", 64'(lat), 64'(C_DIV_LAT));
        check("divu_by0_result", {hi_out, lo_out}, {32'd100, 32'hFFFF_FFFF});

        // Signed overflow, positive/negative divide, signed divide by zero
        do_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, '0, lat);
        check("div_overflow", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
        do_op(C_DIV, 32'd7, 32'hFFFF_FFFE, 0, '0, lat);
        check("div_pos_neg", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFD);
        do_op(C_DIV, 32'hFFFF_FFF9, 32'd0, 0, '0, lat);
        check("div_signed_by0", {hi_out, lo_out}, 64'hFFFF_FFF9_FFFF_FFFF);
        do_op(C_DIVU, 32'hFFFF_FFF9, 32'd2, 0, '0, lat);
        check("divu_large", {hi_out, lo_out}, 64'h0000_0001_7FFF_FFFC);
        tick;

        // MTHI/MTLO on consecutive cycles
        start = 1'b1; op = C_MTHI; a = 32'h1234_5678; tick;
        check("mthi_value", {32'd0, hi_out}, 64'h1234_5678);
        check("mthi_no_busy_done", {62'd0, busy, done}, 64'd0);
        op = C_MTLO; a = 32'h9ABC_DEF0; tick;
        start = 1'b0;
        check("mtlo_value", {hi_out, lo_out}, 64'h1234_5678_9ABC_DEF0);
        check("mtlo_no_busy_done", {62'd0, busy, done}, 64'd0);
        tick;
        check("mt_done_quiet", {63'd0, done}, 64'd0);

        // Abort DIVU with reset, then MULTU 6*7
        op = C_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        rst = 1'b1; tick; rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi_out, lo_out}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_late_done", {63'd0, saw_done}, 64'd0);
        check("abort_hilo_stay", {hi_out, lo_out}, 64'd0);
        do_op(C_MULTU, 32'd6, 32'd7, 0, '0, lat);
        check("multu_6x7_latency", 64'(lat), 64'(C_MUL_LAT));
        check("multu_6x7_result", {hi_out, lo_out}, 64'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
